// File: rtl/systolic3x3_seq.sv
// systolic3x3_seq: sequencing controller for a 3x3 output-stationary systolic array.
// Latency: START-to-DONE is RUN_CYCLES+12 edges after the START edge with RES_READY tied
//   high (RUN_CYCLES+13 cycles counted inclusively from the START cycle to the DONE cycle).
// Backpressure: the load port is ready only in IDLE; the result port holds index and data
//   while RES_VALID & !RES_READY.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   LD_VALID/LD_READY   operand write handshake; LD_SEL picks A (0) or B (1),
//                       LD_IDX = row*3+col, LD_DATA = element value
//   START               begin a job (honoured in IDLE only)
//   BUSY, DONE          status; DONE is a one-cycle pulse at job end
//   ARR_CLR, ARR_EN     accumulator clear / enable to the array
//   A0/A3/A6, B0/B1/B2  skewed row / column edge streams into the array
//   C_IN                array results, Ck at C_IN[k*DATA_W +: DATA_W]
//   RES_VALID/RES_READY result handshake; RES_IDX row-major index, RES_DATA value

module systolic3x3_seq #(
  parameter int DATA_W     = 32,
  parameter int RUN_CYCLES = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD_VALID,
  output logic                  LD_READY,
  input  logic                  LD_SEL,
  input  logic [3:0]            LD_IDX,
  input  logic [DATA_W-1:0]     LD_DATA,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ARR_CLR,
  output logic                  ARR_EN,
  output logic [DATA_W-1:0]     A0,
  output logic [DATA_W-1:0]     A3,
  output logic [DATA_W-1:0]     A6,
  output logic [DATA_W-1:0]     B0,
  output logic [DATA_W-1:0]     B1,
  output logic [DATA_W-1:0]     B2,
  input  logic [9*DATA_W-1:0]   C_IN,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [3:0]            RES_IDX,
  output logic [DATA_W-1:0]     RES_DATA
);

  // Step counter only needs to cover 0..RUN_CYCLES-1.
  localparam int              STEP_W    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_CAPTURE,
    S_OUTPUT,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_nxt;
  logic              feed_load;
  logic [31:0]       step_ext;

  logic [DATA_W-1:0] a_buf   [9];
  logic [DATA_W-1:0] b_buf   [9];
  logic [DATA_W-1:0] res_buf [9];

  logic [DATA_W-1:0] row_edge     [3];
  logic [DATA_W-1:0] col_edge     [3];
  logic [DATA_W-1:0] row_edge_nxt [3];
  logic [DATA_W-1:0] col_edge_nxt [3];

  logic [3:0]        res_idx;
  logic [DATA_W-1:0] res_data_mux;
  logic              ld_fire;
  logic              res_fire;
  logic              last_res;

  assign ld_fire  = LD_VALID & LD_READY;
  assign res_fire = RES_VALID & RES_READY;
  assign last_res = (res_idx == 4'd8);

  // --------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (START) state_nxt = S_CLEAR;
      S_CLEAR:   state_nxt = S_FEED;
      S_FEED:    if (step == LAST_STEP) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OUTPUT;
      S_OUTPUT:  if (res_fire && last_res) state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status and array control are straight decodes of the state register.
  assign LD_READY  = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FIN);
  assign ARR_CLR   = (state == S_CLEAR);
  assign ARR_EN    = (state == S_FEED);
  assign RES_VALID = (state == S_OUTPUT);

  // --------------------------------------------------------------------------
  // Feed step sequencing. The edge registers are loaded one edge ahead of the
  // FEED cycle they belong to: the CLEAR->FEED edge loads step 0, and each
  // FEED edge loads the following step. The edge that leaves FEED loads zeros,
  // so the edges read 0 during CAPTURE and everywhere else.
  // --------------------------------------------------------------------------
  always_comb begin
    feed_load = 1'b0;
    step_nxt  = '0;
    if (state == S_CLEAR) begin
      feed_load = 1'b1;
    end else if ((state == S_FEED) && (step != LAST_STEP)) begin
      feed_load = 1'b1;
      step_nxt  = step + 1'b1;
    end
  end

  assign step_ext = 32'(step_nxt);

  // Skew: row r sees A[r][t-r] and column c sees B[t-c][c] while the offset
  // falls in 0..2; outside that window the edge carries 0.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_edge_nxt[r] = '0;
      col_edge_nxt[r] = '0;
    end
    if (feed_load) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < 3; k++) begin
          if (step_ext == 32'(r + k)) begin
            row_edge_nxt[r] = a_buf[r*3 + k];
            col_edge_nxt[r] = b_buf[k*3 + r];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      step <= '0;
      for (int r = 0; r < 3; r++) begin
        row_edge[r] <= '0;
        col_edge[r] <= '0;
      end
    end else begin
      step <= step_nxt;
      for (int r = 0; r < 3; r++) begin
        row_edge[r] <= row_edge_nxt[r];
        col_edge[r] <= col_edge_nxt[r];
      end
    end
  end

  assign A0 = row_edge[0];
  assign A3 = row_edge[1];
  assign A6 = row_edge[2];
  assign B0 = col_edge[0];
  assign B1 = col_edge[1];
  assign B2 = col_edge[2];

  // --------------------------------------------------------------------------
  // Operand buffers. Writes to indices 9..15 complete the handshake but match
  // no entry, so they are dropped. Contents survive across jobs.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 9; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else if (ld_fire) begin
      for (int k = 0; k < 9; k++) begin
        if (LD_IDX == 4'(k)) begin
          if (LD_SEL) begin
            b_buf[k] <= LD_DATA;
          end else begin
            a_buf[k] <= LD_DATA;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result capture and streaming. The array's last enabled edge closes the
  // final FEED cycle, so C_IN is settled throughout CAPTURE and is latched on
  // the edge leaving it.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 9; k++) begin
        res_buf[k] <= '0;
      end
    end else if (state == S_CAPTURE) begin
      for (int k = 0; k < 9; k++) begin
        res_buf[k] <= C_IN[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_idx <= '0;
    end else if (state == S_CAPTURE) begin
      res_idx <= '0;
    end else if (res_fire) begin
      // Wrap back to 0 after the last element so idle outputs read 0.
      res_idx <= last_res ? 4'd0 : (res_idx + 4'd1);
    end
  end

  always_comb begin
    res_data_mux = '0;
    if (RES_VALID) begin
      for (int k = 0; k < 9; k++) begin
        if (res_idx == 4'(k)) res_data_mux = res_buf[k];
      end
    end
  end

  assign RES_IDX  = res_idx;
  assign RES_DATA = res_data_mux;

endmodule
